adler32_framer: RTL and testbench

ADLER32_FRAMER -- requirements
Module: adler32_framer

---
 rtl/adler32_pkg.sv | 17 +
 rtl/adler32_frame_ram.sv | 43 ++++
 rtl/adler32_framer.sv | 153 +++++++++++++++
 tb/tb_adler32_framer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adler32_pkg.sv
// Shared definitions for the adler32 framing path.
//   SIZE_W          width of the frame-length word handed to the adler32 stage
//   DATA_W          byte width of the framed stream
//   framer_state_t  framer FSM encoding (FILL, SIZE, DATA, WAIT)
package adler32_pkg;

  localparam int SIZE_W = 32;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SIZE = 2'd1,
    DATA = 2'd2,
    WAIT = 2'd3
  } framer_state_t;

endpackage

// File: rtl/adler32_frame_ram.sv
// Frame buffer: DEPTH x DATA_W, one write port and one registered read port.
// Contents are never reset.
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write byte
//   rd_en    read strobe; when low the read register loads zero
//   rd_addr  read address
//   rd_data  registered read byte
module adler32_frame_ram
  import adler32_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register doubles as the framer's data output, so an idle read
  // loads zero instead of holding the previous byte.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/adler32_framer.sv
// Store-and-forward framer in front of an adler32 stage. Buffers one frame,
// announces its length, replays the bytes back-to-back, then waits for the
// checksum stage to report completion before accepting the next frame.
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last   upstream byte stream
//   size_valid/size one-cycle frame length announcement
//   data_start/data replayed frame bytes, data_start on the first
//   checksum_valid  completion pulse from the adler32 stage (honoured in WAIT)
//   overflow        pulse when a frame is cut at DEPTH bytes
//   busy            high whenever the framer is not filling
module adler32_framer
  import adler32_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              size_valid,
  output logic [SIZE_W-1:0] size,
  output logic              data_start,
  output logic [DATA_W-1:0] data,
  input  logic              checksum_valid,
  output logic              overflow,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  framer_state_t state, state_nxt;

  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] len;
  logic [CW-1:0] wr_cnt_inc;
  logic [CW-1:0] rd_cnt_inc;
  logic [CW-1:0] last_idx;
  logic          accept;
  logic          frame_end;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  assign wr_cnt_inc = wr_cnt + 1'b1;
  assign rd_cnt_inc = rd_cnt + 1'b1;
  assign last_idx   = len - 1'b1;
  assign accept     = in_valid && in_ready && (state == FILL) && !rst;
  assign frame_end  = accept && (in_last || (wr_cnt_inc == DEPTH_C));

  adler32_frame_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_cnt[AW-1:0]),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (data)
  );

  always_ff @(posedge clk) begin
    state <= state_nxt;
  end

  // Read is issued one cycle ahead of presentation: address 0 in SIZE, then
  // rd_cnt+1 while byte rd_cnt is on the output.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state)
      FILL: begin
        if (frame_end) begin
          state_nxt = SIZE;
        end
      end
      SIZE: begin
        rd_en     = 1'b1;
        rd_addr   = '0;
        state_nxt = DATA;
      end
      DATA: begin
        if (rd_cnt == last_idx) begin
          state_nxt = WAIT;
        end else begin
          rd_en   = 1'b1;
          rd_addr = rd_cnt_inc[AW-1:0];
        end
      end
      WAIT: begin
        if (checksum_valid) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
    if (rst) begin
      state_nxt = FILL;
      rd_en     = 1'b0;
    end
  end

  // in_ready and busy are registered copies of the next-state decode, so
  // they line up with the state register and carry no path from in_valid
  // within a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      size_valid <= 1'b0;
      size       <= '0;
      data_start <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      in_ready   <= (state_nxt == FILL);
      busy       <= (state_nxt != FILL);
      size_valid <= (state == FILL) && frame_end;
      overflow   <= (state == FILL) && frame_end && !in_last;
      data_start <= (state == SIZE);
      if (accept) begin
        wr_cnt <= wr_cnt_inc;
      end
      if ((state == FILL) && frame_end) begin
        size <= SIZE_W'(wr_cnt_inc);
      end
      if (state == SIZE) begin
        rd_cnt <= '0;
      end else if (state == DATA) begin
        rd_cnt <= rd_cnt_inc;
      end
      if ((state == WAIT) && checksum_valid) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
      end
    end
  end

  // Frame length only changes when a new frame closes; it is not reset.
  always_ff @(posedge clk) begin
    if (!rst && (state == FILL) && frame_end) begin
      len <= wr_cnt_inc;
    end
  end

endmodule

// File: tb/tb_adler32_framer.sv
module tb_adler32_framer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        size_valid;
  logic [31:0] size;
  logic        data_start;
  logic [7:0]  data;
  logic        checksum_valid;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [8:0] src_q[$];   // {last, byte} waiting at the source
  logic [7:0] acc_q[$];   // bytes accepted into the current frame
  logic [7:0] rx_q[$];    // bytes seen on data for the current frame
  bit         acc_now;
  bit         acc_last;

  adler32_framer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .size_valid     (size_valid),
    .size           (size),
    .data_start     (data_start),
    .data           (data),
    .checksum_valid (checksum_valid),
    .overflow       (overflow),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $display("FAIL %s observed=timeout expected=event", tag);
  endtask

  function automatic logic [31:0] adler32(input logic [7:0] q[$]);
    int unsigned a = 1;
    int unsigned b = 0;
    foreach (q[i]) begin
      a = (a + q[i]) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  // One clock: drive the source head, note whether the framer takes it,
  // and return at the following falling edge with outputs settled.
  task automatic cycle();
    bit rdy;
    if (src_q.size() > 0) begin
      in_valid = 1'b1;
      in_data  = src_q[0][7:0];
      in_last  = src_q[0][8];
    end else begin
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_last  = 1'b0;
    end
    rdy = in_ready;
    @(posedge clk);
    acc_now = 1'b0;
    if (rdy && in_valid && !rst) begin
      acc_q.push_back(in_data);
      acc_now  = 1'b1;
      acc_last = in_last;
      void'(src_q.pop_front());
    end
    @(negedge clk);
    checksum_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_in_ready"},   in_ready,   1'b0);
    chk({nm, "_size_valid"}, size_valid, 1'b0);
    chk({nm, "_size"},       size,       32'd0);
    chk({nm, "_data_start"}, data_start, 1'b0);
    chk({nm, "_data"},       data,       8'h00);
    chk({nm, "_overflow"},   overflow,   1'b0);
    chk({nm, "_busy"},       busy,       1'b0);
  endtask

  // Feed until the model says the frame closes (last byte or DEPTH bytes),
  // then follow SIZE, DATA and WAIT and finish with a checksum_valid pulse.
  task automatic run_frame(input string nm, input int exp_n, input logic [31:0] exp_cs,
                           input bit chk_cs, input int rst_at, input int wait_cyc);
    bit done = 0;
    int n;
    for (int g = 0; g < 200 && !done; g++) begin
      cycle();
      if (acc_now && (acc_last || acc_q.size() == DEPTH)) done = 1;
      else chk({nm, "_no_size_valid"}, size_valid, 1'b0);
    end
    if (!done) begin
      timeout_fail({nm, "_feed"});
      return;
    end
    n = acc_q.size();
    chk({nm, "_frame_len"},   n,          exp_n);
    chk({nm, "_size_valid"},  size_valid, 1'b1);
    chk({nm, "_size"},        size,       n);
    chk({nm, "_overflow"},    overflow,   !acc_last);
    chk({nm, "_sz_in_ready"}, in_ready,   1'b0);
    chk({nm, "_sz_busy"},     busy,       1'b1);
    chk({nm, "_sz_start"},    data_start, 1'b0);
    chk({nm, "_sz_data"},     data,       8'h00);
    rx_q.delete();
    for (int i = 0; i < n; i++) begin
      cycle();
      chk({nm, "_data_start"}, data_start, (i == 0));
      chk({nm, "_data"},       data,       acc_q[i]);
      chk({nm, "_d_size_vld"}, size_valid, 1'b0);
      chk({nm, "_d_overflow"}, overflow,   1'b0);
      chk({nm, "_d_in_ready"}, in_ready,   1'b0);
      rx_q.push_back(data);
      if (i == rst_at) begin
        rst = 1'b1;
        cycle();
        chk_reset_outputs({nm, "_rst"});
        rst = 1'b0;
        cycle();
        chk({nm, "_rst_in_ready"}, in_ready, 1'b1);
        for (int k = 0; k < 6; k++) begin
          cycle();
          chk({nm, "_rst_no_start"}, data_start, 1'b0);
          chk({nm, "_rst_no_size"},  size_valid, 1'b0);
        end
        acc_q.delete();
        return;
      end
    end
    cycle();
    chk({nm, "_w_busy"},     busy,       1'b1);
    chk({nm, "_w_data"},     data,       8'h00);
    chk({nm, "_w_start"},    data_start, 1'b0);
    chk({nm, "_w_in_ready"}, in_ready,   1'b0);
    if (chk_cs) chk({nm, "_checksum"}, adler32(rx_q), exp_cs);
    for (int k = 0; k < wait_cyc; k++) begin
      cycle();
      chk({nm, "_hold_in_ready"}, in_ready, 1'b0);
      chk({nm, "_hold_busy"},     busy,     1'b1);
    end
    checksum_valid = 1'b1;
    cycle();
    chk({nm, "_done_in_ready"}, in_ready, 1'b1);
    chk({nm, "_done_busy"},     busy,     1'b0);
    acc_q.delete();
  endtask

  task automatic push_bytes(input logic [7:0] b[], input bit last_on_final);
    foreach (b[i]) src_q.push_back({(last_on_final && i == b.size() - 1), b[i]});
  endtask

  initial begin
    logic [7:0] hello[] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    logic [7:0] one[]   = '{8'h61};
    logic [7:0] b[];
    int len;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    checksum_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    cycle();
    chk("post_reset_in_ready", in_ready, 1'b1);
    chk("post_reset_busy",     busy,     1'b0);

    push_bytes(hello, 1'b1);
    run_frame("hello", 5, 32'h058C01F5, 1'b1, -1, 2);

    push_bytes(one, 1'b1);
    run_frame("single", 1, 32'h00620062, 1'b1, -1, 0);

    // Stray checksum_valid while filling
    b = new[2];
    b[0] = 8'h11;
    b[1] = 8'h22;
    push_bytes(b, 1'b0);
    for (int g = 0; g < 10 && src_q.size() > 0; g++) begin
      cycle();
      chk("stray_no_size", size_valid, 1'b0);
    end
    if (src_q.size() != 0) timeout_fail("stray_feed");
    checksum_valid = 1'b1;
    cycle();
    chk("stray_in_ready", in_ready, 1'b1);
    chk("stray_busy",     busy,     1'b0);
    b = new[1];
    b[0] = 8'h33;
    push_bytes(b, 1'b1);
    run_frame("stray", 3, 32'h0, 1'b0, -1, 1);

    // 20 bytes, the first 16 without last: truncation plus backpressure
    b = new[20];
    foreach (b[i]) b[i] = 8'(i);
    push_bytes(b, 1'b1);
    run_frame("ovf", 16, 32'h0, 1'b0, -1, 3);
    chk("ovf_pending", src_q.size(), 4);
    chk("ovf_next_head", src_q[0][7:0], 8'h10);
    run_frame("ovf_rest", 4, 32'h0, 1'b0, -1, 0);

    // Reset on the third DATA cycle, then a clean frame
    b = new[5];
    foreach (b[i]) b[i] = 8'($urandom_range(0, 255));
    push_bytes(b, 1'b1);
    run_frame("mid_rst", 5, 32'h0, 1'b0, 2, 0);
    push_bytes(hello, 1'b1);
    run_frame("after_rst", 5, 32'h058C01F5, 1'b1, -1, 1);

    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, DEPTH);
      b = new[len];
      foreach (b[i]) b[i] = 8'($urandom_range(0, 255));
      push_bytes(b, 1'b1);
      run_frame("rand", len, adler32(b), 1'b1, -1, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
